conv_pe_stream: RTL and testbench

//  Next-generation convolution processing element: multi-channel KxK signed convolution over one input tile.

---
 rtl/conv_pe_pkg.sv | 17 +
 rtl/conv_pe_stream_if.sv | 39 +++
 rtl/pe_window_dot.sv | 34 +++
 rtl/conv_pe_stream.sv | 184 ++++++++++++++++++
 tb/tb_conv_pe_stream.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pe_pkg.sv
// Shared types and sizing helpers for the streaming convolution processing element.
package conv_pe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Headroom added on top of the product width for accumulating up to 256 terms.
  localparam int ACC_GUARD = 8;

  function automatic int out_dim(input int t, input int k, input int s);
    return (t - k) / s + 1;
  endfunction

endpackage

// File: rtl/conv_pe_stream_if.sv
// Tile-in / result-out handshake bundle between the tile loader, the PE and writeback.
interface conv_pe_stream_if
  import conv_pe_pkg::*;
#(
  parameter int KERNEL_SIZE       = 3,
  parameter int INPUT_TILE_SIZE   = 4,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int CHANNELS          = 3,
  parameter int STRIDE            = 1
);

  localparam int OUT_DIM = out_dim(INPUT_TILE_SIZE, KERNEL_SIZE, STRIDE);
  localparam int ACC_W   = INPUT_DATA_WIDTH + KERNEL_DATA_WIDTH + ACC_GUARD;
  localparam int KERN_W  = KERNEL_SIZE * KERNEL_SIZE * KERNEL_DATA_WIDTH * CHANNELS;
  localparam int DATA_W  = INPUT_TILE_SIZE * INPUT_TILE_SIZE * INPUT_DATA_WIDTH * CHANNELS;
  localparam int OUT_W   = OUT_DIM * OUT_DIM * ACC_W;

  logic              in_valid;
  logic              in_ready;
  logic              relu_en;
  logic [KERN_W-1:0] Kernel;
  logic [DATA_W-1:0] inpData;
  logic [OUT_W-1:0]  outData;
  logic              out_valid;
  logic              out_ready;
  logic              finalCompute;

  modport master (
    output in_valid, relu_en, Kernel, inpData, out_ready,
    input  in_ready, outData, out_valid, finalCompute
  );

  modport slave (
    input  in_valid, relu_en, Kernel, inpData, out_ready,
    output in_ready, outData, out_valid, finalCompute
  );

endinterface

// File: rtl/pe_window_dot.sv
// Combinational signed dot product of one KxK activation window with one KxK kernel channel.
module pe_window_dot #(
  parameter int K     = 3,
  parameter int IDW   = 8,
  parameter int KDW   = 8,
  parameter int ACC_W = 24
) (
  input  logic [K*K*IDW-1:0]       win,
  input  logic [K*K*KDW-1:0]       kern,
  output logic signed [ACC_W-1:0]  dot
);

  logic signed [IDW-1:0]   a;
  logic signed [KDW-1:0]   b;
  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;

  // NOTE: combinational temporaries use blocking '=' so each loop pass sees the previous partial sum.
  always_comb begin
    dot   = '0;
    a     = '0;
    b     = '0;
    a_ext = '0;
    b_ext = '0;
    for (int i = 0; i < K * K; i++) begin
      a     = win[i*IDW +: IDW];
      b     = kern[i*KDW +: KDW];
      a_ext = a;
      b_ext = b;
      dot   = dot + a_ext * b_ext;
    end
  end

endmodule

// File: rtl/conv_pe_stream.sv
// Streaming multi-channel KxK convolution PE: one (pixel, channel) window per cycle,
// channel sums accumulated, optional ReLU, result held under a valid/ready handshake.
module conv_pe_stream
  import conv_pe_pkg::*;
#(
  parameter int KERNEL_SIZE       = 3,
  parameter int INPUT_TILE_SIZE   = 4,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int CHANNELS          = 3,
  parameter int STRIDE            = 1
) (
  input logic              clk,
  input logic              reset,
  conv_pe_stream_if.slave  bus
);

  localparam int K       = KERNEL_SIZE;
  localparam int T       = INPUT_TILE_SIZE;
  localparam int IDW     = INPUT_DATA_WIDTH;
  localparam int KDW     = KERNEL_DATA_WIDTH;
  localparam int C       = CHANNELS;
  localparam int S       = STRIDE;
  localparam int OUT_DIM = out_dim(T, K, S);
  localparam int ACC_W   = IDW + KDW + ACC_GUARD;
  localparam int KERN_W  = K * K * KDW * C;
  localparam int DATA_W  = T * T * IDW * C;
  localparam int OUT_W   = OUT_DIM * OUT_DIM * ACC_W;
  localparam int DIM_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int CH_W    = (C > 1) ? $clog2(C) : 1;

  localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(OUT_DIM - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(C - 1);

  if ((T < K) || (((T - K) % S) != 0) || (K * K * C > 256)) begin : g_cfg_err
    $error("conv_pe_stream: need T >= K, (T-K) %% S == 0 and K*K*C <= 256");
  end

  state_e                  state_q, state_d;
  logic [DIM_W-1:0]        orow_q, orow_d;
  logic [DIM_W-1:0]        ocol_q, ocol_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        out_q, out_d;
  logic                    fc_q, fc_d;

  logic [KERN_W-1:0]       kern_q;
  logic [DATA_W-1:0]       data_q;
  logic                    relu_q;

  logic                    load;
  logic                    in_ready;
  logic [K*K*IDW-1:0]      win;
  logic [K*K*KDW-1:0]      kern_win;
  logic signed [ACC_W-1:0] dot;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] res;
  int                      row0, col0, chn, pix_base;

  // Window and kernel-channel selection for the current (pixel, channel).
  always_comb begin
    row0     = int'(orow_q) * S;
    col0     = int'(ocol_q) * S;
    chn      = int'(ch_q);
    win      = '0;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        win[(kr*K + kc)*IDW +: IDW] = data_q[((chn*T + row0 + kr)*T + col0 + kc)*IDW +: IDW];
      end
    end
    kern_win = kern_q[chn*K*K*KDW +: K*K*KDW];
  end

  pe_window_dot #(
    .K     (K),
    .IDW   (IDW),
    .KDW   (KDW),
    .ACC_W (ACC_W)
  ) u_dot (
    .win  (win),
    .kern (kern_win),
    .dot  (dot)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    orow_d   = orow_q;
    ocol_d   = ocol_q;
    ch_d     = ch_q;
    acc_d    = acc_q;
    out_d    = out_q;
    fc_d     = 1'b0;
    load     = 1'b0;
    in_ready = 1'b0;
    sum      = acc_q + dot;
    res      = (relu_q && sum[ACC_W-1]) ? '0 : sum;
    pix_base = (int'(orow_q) * OUT_DIM + int'(ocol_q)) * ACC_W;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = COMPUTE;
          orow_d  = '0;
          ocol_d  = '0;
          ch_d    = '0;
          acc_d   = '0;
        end
      end
      COMPUTE: begin
        if (ch_q == CH_LAST) begin
          out_d[pix_base +: ACC_W] = res;
          acc_d = '0;
          ch_d  = '0;
          if (ocol_q == DIM_LAST) begin
            ocol_d = '0;
            if (orow_q == DIM_LAST) begin
              orow_d  = '0;
              state_d = DONE;
              fc_d    = 1'b1;
            end else begin
              orow_d = orow_q + 1'b1;
            end
          end else begin
            ocol_d = ocol_q + 1'b1;
          end
        end else begin
          acc_d = sum;
          ch_d  = ch_q + 1'b1;
        end
      end
      DONE: begin
        // Accepting on the draining edge lets back-to-back tiles run with no bubble.
        in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load    = 1'b1;
            state_d = COMPUTE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      orow_q  <= '0;
      ocol_q  <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      fc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      fc_q    <= fc_d;
    end
  end

  // NOTE: the tile copies carry no reset; they are always loaded before COMPUTE reads them.
  always_ff @(posedge clk) begin
    if (load) begin
      kern_q <= bus.Kernel;
      data_q <= bus.inpData;
      relu_q <= bus.relu_en;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.finalCompute = fc_q;
  assign bus.outData      = out_q;

endmodule

// File: tb/tb_conv_pe_stream.sv
// Directed bench for conv_pe_stream: default 4x4/3x3/3ch instance and a 5x5/stride-2/1ch instance.
module tb_conv_pe_stream;
  import conv_pe_pkg::*;

  typedef struct {
    logic [383:0] inp;
    logic [215:0] kern;
    logic         relu;
    logic [95:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  conv_pe_stream_if ifa ();
  conv_pe_stream_if #(.INPUT_TILE_SIZE(5), .CHANNELS(1), .STRIDE(2)) ifb ();

  conv_pe_stream dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  conv_pe_stream #(.INPUT_TILE_SIZE(5), .CHANNELS(1), .STRIDE(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] exp4(input int p3, input int p2, input int p1, input int p0);
    return {24'(p3), 24'(p2), 24'(p1), 24'(p0)};
  endfunction

  function automatic logic [383:0] in_const(input int v);
    logic [383:0] r;
    for (int i = 0; i < 48; i++) r[i*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [383:0] in_ramp_ch0();
    logic [383:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++) r[(row*4 + col)*8 +: 8] = 8'(row*4 + col);
    return r;
  endfunction

  function automatic logic [215:0] k_const(input int v);
    logic [215:0] r;
    for (int i = 0; i < 27; i++) r[i*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [215:0] k_single_ch0(input int kr, input int kc, input int v);
    logic [215:0] r;
    r = '0;
    r[(kr*3 + kc)*8 +: 8] = 8'(v);
    return r;
  endfunction

  // Waits for out_valid on the default instance; lat = edges since the accepting edge, -1 on timeout.
  task automatic wait_valid_a(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (ifa.out_valid) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic send_a(input vec_t v);
    ifa.inpData  = v.inp;
    ifa.Kernel   = v.kern;
    ifa.relu_en  = v.relu;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    ifa.inpData  = ~v.inp;
    ifa.Kernel   = ~v.kern;
    ifa.relu_en  = ~v.relu;
  endtask

  task automatic run_a(input vec_t v, input string name);
    int lat;
    check({name, " in_ready_idle"}, ifa.in_ready, 1'b1);
    send_a(v);
    wait_valid_a(lat);
    check({name, " latency"}, lat, 12);
    check({name, " fc_rise"}, ifa.finalCompute, 1'b1);
    check({name, " data"}, ifa.outData, v.exp);
    tick();
    check({name, " fc_one_cycle"}, ifa.finalCompute, 1'b0);
    check({name, " valid_held"}, ifa.out_valid, 1'b1);
    check({name, " in_ready_stall"}, ifa.in_ready, 1'b0);
    check({name, " data_held"}, ifa.outData, v.exp);
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    check({name, " valid_drop"}, ifa.out_valid, 1'b0);
    check({name, " back_idle"}, ifa.in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         vecs [7];
    int           lat;
    int           seen;
    logic [199:0] b_in;
    logic [71:0]  b_k;

    vecs[0] = '{in_const(1),  k_const(1),          1'b0, exp4(27, 27, 27, 27)};
    vecs[1] = '{in_const(-1), k_const(1),          1'b0, exp4(-27, -27, -27, -27)};
    vecs[2] = '{in_const(-1), k_const(1),          1'b1, exp4(0, 0, 0, 0)};
    vecs[3] = '{in_ramp_ch0(), k_single_ch0(0, 0, 1), 1'b0, exp4(5, 4, 1, 0)};
    vecs[4] = '{in_const(2),  k_const(-1),         1'b0, exp4(-54, -54, -54, -54)};
    vecs[5] = '{in_const(2),  k_const(-1),         1'b1, exp4(0, 0, 0, 0)};
    vecs[6] = '{in_const(1),  k_const(1),          1'b1, exp4(27, 27, 27, 27)};

    reset         = 1'b1;
    ifa.in_valid  = 1'b0;
    ifa.relu_en   = 1'b0;
    ifa.Kernel    = '0;
    ifa.inpData   = '0;
    ifa.out_ready = 1'b0;
    ifb.in_valid  = 1'b0;
    ifb.relu_en   = 1'b0;
    ifb.Kernel    = '0;
    ifb.inpData   = '0;
    ifb.out_ready = 1'b0;
    tick();
    tick();
    check("rst a out_valid", ifa.out_valid, 1'b0);
    check("rst a fc", ifa.finalCompute, 1'b0);
    check("rst a outData", ifa.outData, 96'd0);
    check("rst a in_ready", ifa.in_ready, 1'b1);
    check("rst b out_valid", ifb.out_valid, 1'b0);
    check("rst b in_ready", ifb.in_ready, 1'b1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_a(vecs[i], $sformatf("vec%0d", i));

    // Stride-2, single channel: input r*5+c, weight (1,1)=2.
    b_in = '0;
    for (int row = 0; row < 5; row++)
      for (int col = 0; col < 5; col++) b_in[(row*5 + col)*8 +: 8] = 8'(row*5 + col);
    b_k = '0;
    b_k[(1*3 + 1)*8 +: 8] = 8'd2;
    ifb.inpData  = b_in;
    ifb.Kernel   = b_k;
    ifb.in_valid = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
    ifb.inpData  = '1;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (ifb.out_valid) begin
        lat = i;
        break;
      end
    end
    check("stride2 latency", lat, 4);
    check("stride2 fc", ifb.finalCompute, 1'b1);
    check("stride2 data", ifb.outData, exp4(36, 32, 16, 12));
    ifb.out_ready = 1'b1;
    tick();
    ifb.out_ready = 1'b0;
    check("stride2 drop", ifb.out_valid, 1'b0);

    // Back-to-back: tile B accepted on the same edge that A is consumed.
    send_a(vecs[0]);
    wait_valid_a(lat);
    check("b2b A latency", lat, 12);
    check("b2b A data", ifa.outData, vecs[0].exp);
    ifa.inpData   = vecs[3].inp;
    ifa.Kernel    = vecs[3].kern;
    ifa.relu_en   = vecs[3].relu;
    ifa.in_valid  = 1'b1;
    ifa.out_ready = 1'b1;
    #1;
    check("b2b in_ready follows out_ready", ifa.in_ready, 1'b1);
    tick();
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b0;
    ifa.inpData   = '0;
    check("b2b A consumed", ifa.out_valid, 1'b0);
    check("b2b busy", ifa.in_ready, 1'b0);
    wait_valid_a(lat);
    check("b2b B latency", lat, 12);
    check("b2b B data", ifa.outData, vecs[3].exp);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("b2b B hold%0d", i), {ifa.out_valid, ifa.outData}, {1'b1, vecs[3].exp});
    end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    check("b2b B drop", ifa.out_valid, 1'b0);

    // Reset during COMPUTE aborts the tile with no pulse.
    send_a(vecs[1]);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("midrst out_valid", ifa.out_valid, 1'b0);
    check("midrst fc", ifa.finalCompute, 1'b0);
    check("midrst outData", ifa.outData, 96'd0);
    check("midrst in_ready", ifa.in_ready, 1'b1);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (ifa.out_valid || ifa.finalCompute) seen++;
    end
    check("midrst no pulse", seen, 0);
    run_a(vecs[0], "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
